// File: rtl/display_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: digit count,
// blank codes and the active-low gfedcba hex glyph table.
package disp_pkg;

  localparam int N_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;

  // Entry k is the active-low {g,f,e,d,c,b,a} glyph for nibble k (F first in the literal).
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/display_scan_driver_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[nib_i];

endmodule

// File: rtl/display_scan_driver.sv
// 4-digit common-anode scan driver with a tear-free shadow register committed at
// frame end. Optional macro DISPLAY_SCAN_DEADTIME_EN blanks the first DEAD cycles of each slot.
module display_scan_driver
  import disp_pkg::*;
#(
  parameter int N        = 2,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [15:0]         wr_data,
  input  logic [N_DIGITS-1:0] digit_en,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic [N-1:0]        idx
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

`ifdef DISPLAY_SCAN_DEADTIME_EN
  localparam int BLANK_CYC = DEAD;
`else
  // DEAD has no effect in this build: digits switch with no blank gap.
  localparam int BLANK_CYC = DEAD * 0;
`endif

  logic [PW-1:0]         pre_q, pre_d;
  logic [N-1:0]          idx_q, idx_d;
  logic [15:0]           shadow_q, shadow_d;
  logic [15:0]           active_q, active_d;
  logic                  pending_q, pending_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic                  tick_s;
  logic                  frame_end_s;
  logic                  xfer_s;
  logic                  blank_s;
  logic                  show_s;
  logic [3:0]            nib_s;
  logic [6:0]            glyph_s;

  hex_to_7seg u_hex (
    .nib_i (nib_s),
    .seg_o (glyph_s)
  );

  // Prescaler, scan index, handshake/commit and output next-state logic.
  always_comb begin
    tick_s      = (pre_q == PRE_MAX);
    frame_end_s = tick_s && (idx_q == {N{1'b1}});
    xfer_s      = wr_valid && !pending_q;

    pre_d    = tick_s ? {PW{1'b0}} : pre_q + {{(PW-1){1'b0}}, 1'b1};
    idx_d    = tick_s ? idx_q + {{(N-1){1'b0}}, 1'b1} : idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pending_d = pending_q;

    // Transfer needs pending==0 and commit needs pending==1, so they never coincide.
    if (frame_end_s && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (xfer_s) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (idx_q)
      2'd0:    nib_s = active_q[3:0];
      2'd1:    nib_s = active_q[7:4];
      2'd2:    nib_s = active_q[11:8];
      2'd3:    nib_s = active_q[15:12];
      default: nib_s = 4'h0;
    endcase

    blank_s = (int'(pre_q) < BLANK_CYC);
    show_s  = digit_en[idx_q] && !blank_s;

    if (show_s) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph_s;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end
  end

  // State and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= {PW{1'b0}};
      idx_q     <= {N{1'b0}};
      shadow_q  <= 16'h0000;
      active_q  <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign wr_ready = !pending_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign idx      = idx_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized and directed bench for display_scan_driver against a time-based reference model.
module tb_display_scan_driver;

  localparam int PRE  = 4;
  localparam int DEAD = 2;
  localparam int FRM  = 4 * PRE;
`ifdef DISPLAY_SCAN_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  idx;

  int checks   = 0;
  int failures = 0;

  // Reference model state: cycles since reset release plus shadow/active/pending.
  int          m_t       = 0;
  logic [15:0] m_shadow  = 16'h0;
  logic [15:0] m_active  = 16'h0;
  bit          m_pending = 1'b0;

  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic [1:0]  e_idx;
  logic        e_ready;

  display_scan_driver #(.N(2), .PRESCALE(PRE), .DEAD(DEAD)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .digit_en (digit_en),
    .an       (an),
    .seg      (seg),
    .idx      (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model step and comparison of every output.
  always @(posedge clk) begin
    if (!reset) begin
      m_t = 0; m_shadow = 16'h0; m_active = 16'h0; m_pending = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_idx = 2'd0; e_ready = 1'b1;
    end else begin
      int slot;
      int pre;
      slot = (m_t / PRE) % 4;
      pre  = m_t % PRE;
      if (digit_en[slot] && !(DT && pre < DEAD)) begin
        e_an  = 4'hF ^ (4'(1) << slot);
        e_seg = glyph(4'((m_active >> (4 * slot)) & 16'hF));
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end
      if ((m_t % FRM) == FRM - 1 && m_pending) begin
        m_active = m_shadow; m_pending = 1'b0;
      end else if (wr_valid && !m_pending) begin
        m_shadow = wr_data; m_pending = 1'b1;
      end
      m_t++;
      e_idx   = 2'((m_t / PRE) % 4);
      e_ready = !m_pending;
    end
    #1;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("idx", idx, e_idx);
    check("wr_ready", wr_ready, e_ready);
    check("an_onehot", ($countones(~an) <= 1), 1);
  end

  task automatic wait_edges(input int n);
    int g = 0;
    while (m_t < n && g < 2000) begin
      @(posedge clk); #2; g++;
    end
    if (m_t < n) check("wait_timeout", m_t, n);
  endtask

  task automatic write_word(input logic [15:0] d, output int acc);
    int g = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    while (!wr_ready && g < 200) begin
      wr_data = 16'($urandom);
      @(negedge clk); g++;
    end
    if (!wr_ready) check("write_timeout", g, 0);
    wr_data = d;
    @(posedge clk); #2;
    acc = m_t;
  endtask

  task automatic idle;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  int a1, a2, c;

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; digit_en = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    @(negedge clk) reset = 1'b1;

    // Scan sequence after release.
    wait_edges(1);
    check("first_an", an, DT ? 4'hF : 4'hE);
    check("first_seg", seg, DT ? 7'h7F : 7'b1000000);
    wait_edges(4);  check("scan_an0", an, 4'b1110); check("scan_idx1", idx, 2'd1);
    wait_edges(8);  check("scan_an1", an, 4'b1101);
    wait_edges(12); check("scan_an2", an, 4'b1011);
    wait_edges(16); check("scan_an3", an, 4'b0111); check("scan_idx0", idx, 2'd0);

    // Single write, commit at the next frame end.
    write_word(16'h1A3F, a1);
    idle();
    check("ready_drop", wr_ready, 1'b0);
    c = (a1 / FRM + 1) * FRM;
    wait_edges(c);      check("ready_back", wr_ready, 1'b1);
    wait_edges(c + 4);  check("d0_F", seg, 7'b0001110);
    wait_edges(c + 8);  check("d1_3", seg, 7'b0110000);
    wait_edges(c + 12); check("d2_A", seg, 7'b0001000);
    wait_edges(c + 16); check("d3_1", seg, 7'b1111001);

    // Back-to-back writes: second stalls until the first commits.
    write_word(16'h1111, a1);
    write_word(16'h2222, a2);
    idle();
    c = (a1 / FRM + 1) * FRM;
    check("b2b_accept", a2, c + 1);
    wait_edges(c + 4); check("b2b_first", seg, 7'b1111001);
    c = (a2 / FRM + 1) * FRM;
    wait_edges(c + 16); check("b2b_second", seg, 7'b0100100);

    // Write on the frame_end cycle: no commit that frame.
    wait_edges(((m_t + 1) / FRM) * FRM + FRM - 1);
    @(negedge clk); wr_valid = 1'b1; wr_data = 16'h0C0D;
    @(posedge clk); #2; a1 = m_t;
    idle();
    check("fe_accept_edge", a1 % FRM, 0);
    wait_edges(a1 + 15); check("fe_still_pending", wr_ready, 1'b0);
    check("fe_old_digit3", seg, 7'b0100100);
    wait_edges(a1 + 16); check("fe_commit", wr_ready, 1'b1);
    wait_edges(a1 + 20); check("fe_new_d0", seg, 7'b0100001);

    // Digit enables blank slots 1 and 3.
    @(negedge clk) digit_en = 4'b0101;
    write_word(16'h8888, a1);
    idle();
    c = (a1 / FRM + 1) * FRM;
    wait_edges(c + 4);  check("en_s0_an", an, 4'b1110); check("en_s0_seg", seg, 7'b0000000);
    wait_edges(c + 8);  check("en_s1_an", an, 4'b1111); check("en_s1_seg", seg, 7'h7F);
    wait_edges(c + 12); check("en_s2_an", an, 4'b1011);
    wait_edges(c + 16); check("en_s3_seg", seg, 7'h7F);
    @(negedge clk) digit_en = 4'hF;

    // Async reset mid-slot discards the pending write.
    write_word(16'h5555, a1);
    idle();
    @(negedge clk); #2 reset = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_idx", idx, 2'd0);
    check("mid_rst_ready", wr_ready, 1'b1);
    @(negedge clk) reset = 1'b1;
    wait_edges(FRM * 2 + 4); check("post_rst_d0", seg, 7'b1000000);

    // Randomized traffic, enables and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 599) == 0) reset = 1'b0;
    end
    @(negedge clk); wr_valid = 1'b0; reset = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Consumer end of the 2-bit digit-index counter path: owns a free-running 2-bit scan index and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Producer logic writes a 16-bit value (4 hex nibbles) through a valid/ready handshake into a shadow register.
- The shadow register is committed only at a frame boundary, so a displayed frame never tears.
- Sits between the datapath and the board display pins.

Parameters:
- N, 2, scan index width; digit count = 2**N = 4. Only 2 is supported.
- PRESCALE, 50000, clk cycles per digit slot. Must be >= 2.
- DEAD, 2, blanking cycles at the start of each slot. Used only with DEADTIME_EN; must be < PRESCALE.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  producer offers wr_data.
- wr_ready  output  1  block can accept wr_data.
- wr_data  input  16  digit3..digit0 nibbles; [3:0] is digit0.
- digit_en  input  4  per-digit enable; 0 blanks that digit. Sampled live, not shadowed.
- an  output  4  anode select, active-low one-hot.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- idx  output  N  current scan index, for debug and for other blocks.

Behaviour:
- Reset (reset==0, asynchronous):
  - pre=0, idx=0, shadow=0, active=0, pending=0.
  - an=4'b1111, seg=7'b1111111.
- Prescaler:
  - pre counts 0..PRESCALE-1 and wraps to 0.
  - tick = (pre==PRESCALE-1).
- Scan index:
  - On tick, idx <= idx+1, wrapping 3->0 (modulo 2**N).
  - frame_end = tick && idx==3.
- Handshake:
  - wr_ready = !pending (combinational).
  - Transfer occurs when wr_valid && wr_ready: shadow <= wr_data, pending <= 1.
  - wr_data may change freely while wr_ready==0; it is not sampled then.
- Commit:
  - On frame_end with pending==1: active <= shadow, pending <= 0.
  - wr_ready rises the following cycle.
  - The new value is first displayed in the slot where idx==0.
- Simultaneous events:
  - Transfer in the same cycle as frame_end (only possible when pending==0): shadow loads, pending sets, no commit. The commit happens at the next frame_end, 4*PRESCALE cycles later.
  - Back-to-back writes: the second write stalls until the commit.
- Outputs (registered, one cycle after idx/active/digit_en):
  - an = ~(1<<idx).
  - seg = hex7(active[4*idx+:4]) when digit_en[idx]==1; otherwise an=4'b1111 and seg=7'b1111111.
- Hex map (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-operation: all state returns to reset values immediately. Any pending shadow data is discarded.
- an is never multi-hot, in any cycle.

Optional Feature:
- Macro: DISPLAY_SCAN_DEADTIME_EN.
- Defined: for the first DEAD cycles of each slot (pre < DEAD after the index change), an=4'b1111 and seg=7'b1111111, to suppress ghosting. Normal drive resumes after that.
- Undefined: the output switches digits directly, with no blank gap. The DEAD parameter is ignored.

Decomposition:
- Package disp_pkg holds:
  - N_DIGITS = 4
  - SEG_BLANK = 7'h7F
  - AN_OFF = 4'hF
  - the 16-entry hex-to-segment constant table
- One natural sub-module: hex_to_7seg, a purely combinational 4-bit to 7-bit lookup using the package table.
- Prescaler, index, handshake and output registers stay in the top module.

Test Plan:
- Reset hold, then release with PRESCALE=4 -> cycle 1: an=1110, seg=1000000. idx steps 0,1,2,3,0 every 4 cycles; an steps 1110,1101,1011,0111.
- Write wr_data=16'h1A3F at idle -> wr_ready drops the next cycle. At the following frame_end the display commits; frame shows digit0=0001110 (F), digit1=0110000 (3), digit2=0001000 (A), digit3=1111001 (1). wr_ready returns to 1.
- Hold wr_valid with 16'h1111 then 16'h2222 back-to-back -> the second write is accepted only after the first commits. Displayed frames show all-1 then all-2, never mixed.
- Assert wr_valid exactly on the frame_end cycle with pending=0 -> shadow loads, no commit that frame. Commit occurs 16 cycles later.
- digit_en=4'b0101 with value 16'h8888 -> slots 1 and 3 show an=1111, seg=1111111. Slots 0 and 2 show seg=0000000.
- DISPLAY_SCAN_DEADTIME_EN with PRESCALE=4, DEAD=2 -> each slot shows an=1111 for 2 cycles, then the selected digit for 2 cycles. Pulse reset low mid-slot -> an=1111 and seg=1111111 immediately; the pending write is lost.
